clk_div_bank: RTL and testbench
===============================

# clk_div_bank

Multi-channel programmable clock divider. It is the parametrised successor to the single-path clock buffer. It derives NCH independent 50%-duty clocks from one system clock, each with a runtime-programmable ratio and enable. Ratio changes and disables are glitch-free. Outputs feed downstream clock-enable and strobe logic and the frequency-measurement bench.

## Interface
Parameters:
- NCH, 2: number of independent divider channels (≥1).
- DIVW, 8: width of each channel's ratio field; ratio range 1..2^DIVW−1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  NCH  per-channel run request.
- div  in  NCH*DIVW  per-channel half-period ratio R. Channel i uses bits [i*DIVW +: DIVW]. A value of 0 is treated as 1.
- out  out  NCH  divided clock per channel, registered.
- rise  out  NCH  one-cycle pulse, high in the same cycle out[i] becomes 1.
- active  out  NCH  channel i is in RUN state.

## Operation
Each channel has two states, IDLE and RUN. It holds a counter cnt (DIVW bits) and a latched ratio r (DIVW bits). In IDLE, out=0, cnt=0 and r is held.

IDLE → RUN:
- Trigger: en[i]=1 sampled at an edge.
- At that edge: r ← max(div_i,1), cnt ← 0, out ← 1, rise ← 1.

RUN, every edge:
- If cnt == r−1: cnt ← 0 and out toggles.
- Otherwise: cnt ← cnt+1.
- Result: r cycles high, r cycles low, period 2r, exact 50% duty.

Period boundary (out toggling 0→1 at cnt == r−1 while out=0):
- If en[i]=1: r ← max(div_i,1) and out ← 1, rise ← 1. A new ratio takes effect only here, so no runt pulses.
- If en[i]=0: RUN → IDLE, out stays 0, cnt ← 0. A full low phase always completes before idle.

Other boundary rules:
- div changes mid-period are ignored until the next period boundary.
- en deasserting mid-period has no effect until that period's low phase ends.
- en pulsing low then high within one period has no effect; the channel keeps running.
- rise is 0 in every cycle other than the 0→1 transition of out.
- active[i] = (state == RUN). It stays 1 through the final low phase after en drops.
- Channels are fully independent; there is no cross-channel phase alignment.

## Timing
- Reset: out=0, rise=0, active=0, every cnt=0, every r=1, all channels IDLE. Effect is immediate (asynchronous); release is sampled at the next clk edge.
- Reset mid-operation: out drops to 0 without waiting for the period to end.
- Start latency: en[i] sampled high at edge k → out[i]=1, rise[i]=1 after edge k.
- High phase of output period n covers edges k+2nr … k+2nr+r−1; the low phase follows for r cycles.
- Stop latency: en dropped during period n → out=0 and active=0 from the end of period n (edge k+2nr+2r). No new rise occurs after that.
- Output frequency: f_clk/(2·max(div,1)). Example: a 100 MHz clk with div=5 gives 10 MHz.
- All outputs are registered. There is no combinational path from inputs to out, rise or active.

## Structure
- Package clk_div_pkg holds the state encoding constants (IDLE, RUN) and the default DIVW.
- Sub-module clk_div_ch implements one channel: state, cnt, r, out, rise.
- clk_div_bank instantiates NCH copies with a generate loop and slices div per channel.

## Test plan
- Reset/idle: assert rst with en=0 → out, rise and active all 0. Hold for 20 cycles → no activity.
- Basic ratio: NCH=2, div0=3, en0=1 at edge 0 →
  - out0 high for edges 0–2 and low for 3–5, repeating with period 6.
  - rise0 pulses at 0, 6, 12.
  - Measured frequency is f_clk/6.
  - Channel 1 stays idle.
- Ratio 0/1: div=0, then separately div=1 → out toggles every cycle (period 2) and rise pulses every 2 cycles in both cases.
- Glitch-free ratio change: run with div=4, then set div=2 at cnt=1 of a high phase → that period completes as 4+4 cycles, and subsequent periods are 2+2.
- Disable mid-period: with div=3, drop en one cycle into the high phase → high phase finishes (3 cycles), low phase finishes (3 cycles), then out=0 and active=0, with no further rise.
- Reset mid-run: with div=5 and out high, assert rst asynchronously between edges → out=0 immediately. After release with en=1, the restart follows the start latency.

Source files
------------

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants for the clock divider bank
package clk_div_pkg;

  localparam int DEF_DIVW = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one 50%-duty divider channel with glitch-free ratio/enable updates
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIVW = DEF_DIVW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DIVW-1:0] div,
  output logic            out,
  output logic            rise,
  output logic            active
);

  localparam logic [DIVW-1:0] ONE = DIVW'(1);

  logic [0:0]      state;
  logic [DIVW-1:0] cnt;
  logic [DIVW-1:0] r;
  logic [DIVW-1:0] div_eff;
  logic            at_end;

  assign div_eff = (div == '0) ? ONE : div;
  assign at_end  = (cnt == r - ONE);
  assign active  = (state == ST_RUN);

  // en and div are only consulted at the end of a low phase, so every period is whole
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      r     <= ONE;
      out   <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (state == ST_IDLE) begin
        if (en) begin
          state <= ST_RUN;
          r     <= div_eff;
          cnt   <= '0;
          out   <= 1'b1;
          rise  <= 1'b1;
        end
      end else if (!at_end) begin
        cnt <= cnt + ONE;
      end else begin
        cnt <= '0;
        if (out) begin
          out <= 1'b0;
        end else if (en) begin
          r    <= div_eff;
          out  <= 1'b1;
          rise <= 1'b1;
        end else begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - NCH independent programmable clock dividers
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int DIVW = DEF_DIVW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    en,
  input  logic [NCH*DIVW-1:0] div,
  output logic [NCH-1:0]    out,
  output logic [NCH-1:0]    rise,
  output logic [NCH-1:0]    active
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_ch #(
      .DIVW (DIVW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .div    (div[i*DIVW +: DIVW]),
      .out    (out[i]),
      .rise   (rise[i]),
      .active (active[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - directed self-checking bench for clk_div_bank
module tb_clk_div_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en  = 2'b00;
  logic [15:0] div = 16'h0000;
  logic [1:0]  out;
  logic [1:0]  rise;
  logic [1:0]  active;

  int n_cmp = 0;
  int n_bad = 0;

  clk_div_bank #(.NCH(2), .DIVW(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .div    (div),
    .out    (out),
    .rise   (rise),
    .active (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_rise", 32'(rise), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // patterns: bit [n-1-c] is the value expected after edge c; [1] is channel 1
  task automatic run_check(input string name, input int n,
                           input logic [1:0][31:0] op, input logic [1:0][31:0] rp,
                           input logic [1:0][31:0] ap, input int act_c,
                           input logic [1:0] act_en, input logic [15:0] act_div);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 2; ch++) begin
        check($sformatf("%s_out%0d_c%0d", name, ch, c), 32'(out[ch]), 32'(op[ch][n-1-c]));
        check($sformatf("%s_rise%0d_c%0d", name, ch, c), 32'(rise[ch]), 32'(rp[ch][n-1-c]));
        check($sformatf("%s_act%0d_c%0d", name, ch, c), 32'(active[ch]), 32'(ap[ch][n-1-c]));
      end
      if (c == act_c) begin
        en  = act_en;
        div = act_div;
      end
    end
  endtask

  initial begin
    int nrise;
    int any1;

    // reset and idle hold
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("idle_c%0d", c), {26'd0, out, rise, active}, 32'd0);
    end

    // basic ratio 3 on channel 0, channel 1 idle
    do_reset();
    div = {8'd7, 8'd3};
    en  = 2'b01;
    run_check("basic", 18,
              {32'd0, 32'b111000111000111000},
              {32'd0, 32'b100000100000100000},
              {32'd0, 32'b111111111111111111},
              -1, 2'b01, {8'd7, 8'd3});
    nrise = 0;
    any1  = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      nrise += int'(rise[0]);
      any1  += int'(out[1] | active[1]);
    end
    check("basic_rise_count", 32'(nrise), 32'd10);
    check("basic_ch1_quiet", 32'(any1), 32'd0);

    // ratio 0 on channel 0 and ratio 1 on channel 1 both divide by 2
    do_reset();
    div = {8'd1, 8'd0};
    en  = 2'b11;
    run_check("ratio01", 8,
              {32'b10101010, 32'b10101010},
              {32'b10101010, 32'b10101010},
              {32'b11111111, 32'b11111111},
              -1, 2'b11, {8'd1, 8'd0});

    // ratio 4 -> 2 mid high phase: current period stays 4+4
    do_reset();
    div = {8'd0, 8'd4};
    en  = 2'b01;
    run_check("ratchg", 16,
              {32'd0, 32'b1111000011001100},
              {32'd0, 32'b1000000010001000},
              {32'd0, 32'b1111111111111111},
              1, 2'b01, {8'd0, 8'd2});

    // disable one cycle into the high phase: full period completes, then idle
    do_reset();
    div = {8'd0, 8'd3};
    en  = 2'b01;
    run_check("disable", 12,
              {32'd0, 32'b111000000000},
              {32'd0, 32'b100000000000},
              {32'd0, 32'b111111000000},
              0, 2'b00, {8'd0, 8'd3});

    // asynchronous reset while out is high, then restart
    do_reset();
    div = {8'd0, 8'd5};
    en  = 2'b01;
    run_check("prerst", 2,
              {32'd0, 32'b11}, {32'd0, 32'b10}, {32'd0, 32'b11},
              -1, 2'b01, {8'd0, 8'd5});
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_active", 32'(active), 32'd0);
    check("async_rst_rise", 32'(rise), 32'd0);
    #2;
    rst = 1'b0;
    run_check("restart", 11,
              {32'd0, 32'b11111000001},
              {32'd0, 32'b10000000001},
              {32'd0, 32'b11111111111},
              -1, 2'b01, {8'd0, 8'd5});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
